// File: rtl/elevator_ctrl_scan.sv
// elevator_ctrl_scan: N-floor elevator controller core. Calls are latched into
// a pending register and served in SCAN order (keep going the current way
// while calls remain ahead, then reverse). Travel and door dwell are timed by
// per-floor and per-door cycle counters.
// Optional build macro: ELEV_DOOR_REOPEN_EN -- a call for the current floor
// while the door is open restarts the dwell instead of being latched.
module elevator_ctrl_scan #(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned FLOOR_W       = 2,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req_vec,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  state_t                  state, state_n, dec_state;
  logic [FLOOR_W-1:0]      floor_n, step_floor;
  logic                    dir_n, dec_dir;
  logic [NUM_FLOORS-1:0]   pend_n, here_bit, step_bit;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [DW-1:0]           dcnt, dcnt_n;
  logic                    any_above, any_below, here_pend, reopen;

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == f) b[i] = 1'b1;
    end
    return b;
  endfunction

  // Summarise the pending calls relative to the car position.
  always_comb begin
    any_above  = 1'b0;
    any_below  = 1'b0;
    here_bit   = floor_bit(curr_floor);
    here_pend  = |(pending & here_bit);
    step_floor = (state == MOVE_DOWN) ? curr_floor - 1'b1 : curr_floor + 1'b1;
    step_bit   = floor_bit(step_floor);
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > curr_floor) any_above = 1'b1;
        if (FLOOR_W'(i) < curr_floor) any_below = 1'b1;
      end
    end
  end

  // SCAN decision: serve here, else continue the latched direction, else reverse.
  always_comb begin
    dec_state = IDLE;
    dec_dir   = dir_up;
    if (here_pend) begin
      dec_state = DOOR;
    end else if (any_above && dir_up) begin
      dec_state = MOVE_UP;
    end else if (any_below && !dir_up) begin
      dec_state = MOVE_DOWN;
    end else if (any_below) begin
      dec_state = MOVE_DOWN;
      dec_dir   = 1'b0;
    end else if (any_above) begin
      dec_state = MOVE_UP;
      dec_dir   = 1'b1;
    end
  end

  // Next-state, request latch and counter sequencing.
  always_comb begin
    state_n = state;
    floor_n = curr_floor;
    dir_n   = dir_up;
    pend_n  = pending | req_vec;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    reopen  = 1'b0;
`ifdef ELEV_DOOR_REOPEN_EN
    reopen  = |(req_vec & here_bit);
`endif
    unique case (state)
      IDLE: begin
        tcnt_n  = '0;
        dir_n   = dec_dir;
        state_n = dec_state;
        if (dec_state == DOOR) begin
          dcnt_n = '0;
          pend_n = pend_n & ~here_bit;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (tcnt == TRAVEL_LAST) begin
          tcnt_n  = '0;
          floor_n = step_floor;
          if ((pending & step_bit) != '0) begin
            state_n = DOOR;
            dcnt_n  = '0;
            pend_n  = pend_n & ~step_bit;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DOOR: begin
        tcnt_n = '0;
        if (reopen) begin
          dcnt_n = '0;
          pend_n = pend_n & ~here_bit;
        end else if (dcnt == DOOR_LAST) begin
          dcnt_n = '0;
          dir_n  = dec_dir;
          // A renewed call here closes the door for one IDLE cycle; IDLE then reopens it.
          state_n = (dec_state == DOOR) ? IDLE : dec_state;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, position, direction, request and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      curr_floor <= '0;
      dir_up     <= 1'b1;
      pending    <= '0;
      tcnt       <= '0;
      dcnt       <= '0;
    end else begin
      state      <= state_n;
      curr_floor <= floor_n;
      dir_up     <= dir_n;
      pending    <= pend_n;
      tcnt       <= tcnt_n;
      dcnt       <= dcnt_n;
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    motor_up   = (state == MOVE_UP);
    motor_down = (state == MOVE_DOWN);
    door_open  = (state == DOOR);
    busy       = (state != IDLE);
  end

`ifndef SYNTHESIS
  a_floor_bound: assert property (@(posedge clk) disable iff (!reset)
    curr_floor <= FLOOR_W'(NUM_FLOORS - 1));
  a_motor_excl: assert property (@(posedge clk) disable iff (!reset)
    !(motor_up && motor_down));
`endif

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// tb_elevator_ctrl_scan: scenario tasks plus a randomized run checked against
// a deadline-based behavioural model of the SCAN elevator.
`timescale 1ns/1ps
module tb_elevator_ctrl_scan;
  localparam int unsigned NF = 4;
  localparam int unsigned FW = 2;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 8;
`ifdef ELEV_DOOR_REOPEN_EN
  localparam bit REOPEN = 1'b1;
`else
  localparam bit REOPEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] req_vec = '0;
  logic          motor_up, motor_down, door_open, dir_up, busy;
  logic [FW-1:0] curr_floor;
  logic [NF-1:0] pending;
  logic [NF+FW+4:0] dut_vec;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  elevator_ctrl_scan #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .req_vec(req_vec),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .curr_floor(curr_floor), .dir_up(dir_up), .pending(pending), .busy(busy)
  );

  assign dut_vec = {motor_up, motor_down, door_open, curr_floor, dir_up, pending, busy};

  always #5 clk = ~clk;

  // Behavioural model: activity plus the absolute edge number at which it ends.
  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} act_t;
  act_t          m_act;
  int            m_floor;
  bit            m_dir;
  logic [NF-1:0] m_pend;
  longint        m_due;
  longint        cyc = 0;

  function automatic logic [NF+FW+4:0] model_vec();
    return {m_act == M_UP, m_act == M_DOWN, m_act == M_DOOR, FW'(m_floor),
            m_dir, m_pend, m_act != M_IDLE};
  endfunction

  function automatic logic [NF+FW+4:0] reset_vec();
    return {1'b0, 1'b0, 1'b0, {FW{1'b0}}, 1'b1, {NF{1'b0}}, 1'b0};
  endfunction

  task automatic model_reset();
    m_act = M_IDLE; m_floor = 0; m_dir = 1'b1; m_pend = '0; m_due = 0;
  endtask

  task automatic model_decide(input logic [NF-1:0] seen, input bit from_door);
    bit up = 1'b0;
    bit dn = 1'b0;
    for (int i = 0; i < int'(NF); i++) begin
      if (seen[i] && i > m_floor) up = 1'b1;
      if (seen[i] && i < m_floor) dn = 1'b1;
    end
    if (seen[m_floor]) begin
      if (from_door) m_act = M_IDLE;
      else begin m_act = M_DOOR; m_pend[m_floor] = 1'b0; m_due = cyc + DC; end
    end else if (up && (m_dir || !dn)) begin
      m_act = M_UP; m_dir = 1'b1; m_due = cyc + TC;
    end else if (dn) begin
      m_act = M_DOWN; m_dir = 1'b0; m_due = cyc + TC;
    end else begin
      m_act = M_IDLE;
    end
  endtask

  task automatic model_edge(input logic [NF-1:0] req);
    logic [NF-1:0] seen;
    cyc++;
    seen   = m_pend;
    m_pend = m_pend | req;
    case (m_act)
      M_IDLE: model_decide(seen, 1'b0);
      M_UP, M_DOWN: begin
        if (cyc == m_due) begin
          m_floor += (m_act == M_UP) ? 1 : -1;
          if (seen[m_floor]) begin
            m_act = M_DOOR; m_pend[m_floor] = 1'b0; m_due = cyc + DC;
          end else begin
            m_due = cyc + TC;
          end
        end
      end
      M_DOOR: begin
        if (REOPEN && req[m_floor]) begin
          m_pend[m_floor] = 1'b0; m_due = cyc + DC;
        end else if (cyc == m_due) begin
          model_decide(seen, 1'b1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick(input logic [NF-1:0] req);
    req_vec = req;
    @(posedge clk);
    model_edge(req);
    #1;
  endtask

  task automatic wait_floor(input int f, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick('0);
      if (int'(curr_floor) == f) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      tick('0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_vec = '1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== reset_vec()) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec, reset_vec());
    end
    req_vec = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    tick('0);
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_local_call();
    int open_len;
    tick(NF'(1));
    n_checks++;
    if (pending !== NF'(1) || door_open !== 1'b0) begin
      n_fail++; $display("FAIL local_latch: pending %b door %b expected 0001 0", pending, door_open);
    end
    tick('0);
    n_checks++;
    if (door_open !== 1'b1 || pending !== '0) begin
      n_fail++; $display("FAIL local_entry: door %b pending %b expected 1 0000", door_open, pending);
    end
    open_len = 1;
    for (int i = 0; i < 4 * int'(DC); i++) begin
      tick('0);
      if (door_open !== 1'b1) break;
      open_len++;
    end
    n_checks++;
    if (open_len != int'(DC)) begin
      n_fail++; $display("FAIL local_dwell: got %0d cycles expected %0d", open_len, DC);
    end
    n_checks++;
    if (busy !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL local_idle: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_trip();
    logic [NF-1:0] r;
    logic [FW-1:0] last;
    int k_move, ups, downs, door_k, steps;
    bit ok;
    k_move = -1; ups = 0; downs = 0; door_k = -1; steps = 0;
    r = '0; r[NF-1] = 1'b1;
    last = curr_floor;
    tick(r);
    for (int k = 1; k <= 200 && door_k < 0; k++) begin
      tick('0);
      if (motor_up === 1'b1) begin if (k_move < 0) k_move = k; ups++; end
      if (motor_down !== 1'b0) downs++;
      if (curr_floor !== last) begin
        steps++;
        n_checks++;
        if (k_move < 0 || k != k_move + steps * int'(TC) || int'(curr_floor) != steps) begin
          n_fail++; $display("FAIL trip_step: floor %0d at cycle %0d expected floor %0d at %0d",
                             curr_floor, k, steps, k_move + steps * int'(TC));
        end
        last = curr_floor;
      end
      if (door_open === 1'b1) door_k = k;
    end
    n_checks++;
    if (k_move != 1 || ups != int'((NF - 1) * TC) || downs != 0) begin
      n_fail++; $display("FAIL trip_motor: start %0d up %0d down %0d expected 1 %0d 0",
                         k_move, ups, downs, (NF - 1) * TC);
    end
    n_checks++;
    if (door_k != 1 + int'((NF - 1) * TC) || int'(curr_floor) != int'(NF - 1)) begin
      n_fail++; $display("FAIL trip_arrive: door at %0d floor %0d expected %0d %0d",
                         door_k, curr_floor, 1 + (NF - 1) * TC, NF - 1);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL trip_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_move();
    bit ok;
    tick(NF'(1));
    wait_floor(2, ok);
    tick('0);
    n_checks++;
    if (!ok || motor_down !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL midmove_setup: got %b expected %b", dut_vec, model_vec());
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== reset_vec()) begin
      n_fail++; $display("FAIL midmove_async_reset: got %b expected %b", dut_vec, reset_vec());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    tick('0);
    n_checks++;
    if (dut_vec !== reset_vec()) begin
      n_fail++; $display("FAIL midmove_after_release: got %b expected %b", dut_vec, reset_vec());
    end
  endtask

  task automatic test_scan_order();
    logic [NF-1:0] r;
    int got[3];
    bit dir_at[3];
    int n;
    bit prev, ok;
    r = '0; r[3] = 1'b1;
    got = '{-1, -1, -1}; dir_at = '{1'b0, 1'b0, 1'b0}; n = 0; prev = 1'b0;
    tick(r);
    tick('0);
    n_checks++;
    if (motor_up !== 1'b1) begin n_fail++; $display("FAIL scan_start: motor_up %b expected 1", motor_up); end
    tick(NF'(1));
    wait_floor(1, ok);
    tick(NF'(4));
    for (int i = 0; i < 400 && n < 3; i++) begin
      tick('0);
      if (door_open === 1'b1 && !prev) begin got[n] = int'(curr_floor); dir_at[n] = dir_up; n++; end
      prev = door_open;
    end
    n_checks++;
    if (!ok || got[0] != 2 || got[1] != 3 || got[2] != 0) begin
      n_fail++; $display("FAIL scan_order: got %0d,%0d,%0d expected 2,3,0", got[0], got[1], got[2]);
    end
    n_checks++;
    if (dir_at[0] != 1'b1 || dir_at[1] != 1'b1 || dir_at[2] != 1'b0) begin
      n_fail++; $display("FAIL scan_dir: got %b%b%b expected 110", dir_at[0], dir_at[1], dir_at[2]);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL scan_idle: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_late_call();
    logic [NF-1:0] r;
    int got[2];
    int n;
    bit prev, ok;
    r = '0; r[3] = 1'b1;
    got = '{-1, -1}; n = 0; prev = 1'b0;
    tick(r);
    wait_floor(1, ok);
    repeat (TC - 1) tick('0);
    tick(NF'(4));
    n_checks++;
    if (!ok || int'(curr_floor) != 2 || door_open !== 1'b0 || motor_up !== 1'b1 || pending[2] !== 1'b1) begin
      n_fail++; $display("FAIL late_pass: floor %0d door %b up %b pending %b expected 2 0 1 x1xx",
                         curr_floor, door_open, motor_up, pending);
    end
    for (int i = 0; i < 400 && n < 2; i++) begin
      tick('0);
      if (door_open === 1'b1 && !prev) begin got[n] = int'(curr_floor); n++; end
      prev = door_open;
    end
    n_checks++;
    if (got[0] != 3 || got[1] != 2) begin
      n_fail++; $display("FAIL late_order: got %0d,%0d expected 3,2", got[0], got[1]);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL late_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_reopen();
    localparam int K = 6;
    bit trace[100];
    int idx, r1, g, r2, exp_r1, exp_g, exp_r2;
    bit ok;
    tick(NF'(4));
    tick('0);
    trace[0] = door_open;
    for (int c = 1; c < 100; c++) begin
      tick((c == K) ? NF'(4) : NF'(0));
      trace[c] = door_open;
    end
    idx = 0; r1 = 0; g = 0; r2 = 0;
    while (idx < 100 && trace[idx]) begin r1++; idx++; end
    while (idx < 100 && !trace[idx]) begin g++; idx++; end
    while (idx < 100 && trace[idx]) begin r2++; idx++; end
    exp_r1 = REOPEN ? K + int'(DC) : int'(DC);
    exp_g  = REOPEN ? 100 - exp_r1 : 1;
    exp_r2 = REOPEN ? 0 : int'(DC);
    n_checks++;
    if (r1 != exp_r1 || g != exp_g || r2 != exp_r2) begin
      n_fail++; $display("FAIL reopen_pattern: open/closed/open %0d/%0d/%0d expected %0d/%0d/%0d",
                         r1, g, r2, exp_r1, exp_g, exp_r2);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || pending !== '0 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reopen_idle: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    logic [NF-1:0] r;
    reset = 1'b0; req_vec = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 5) == 0) ? NF'($urandom) : NF'(0);
      tick(r);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_local_call();
    test_single_trip();
    test_reset_mid_move();
    test_scan_order();
    test_late_call();
    test_reopen();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
